// File: rtl/pattern_fetch_driver_pkg.sv
// Shared constants, FSM encoding and the per-channel word merge for the
// pattern fetch driver.
package pattern_fetch_driver_pkg;

  localparam int DEF_MEM_ADDRESS_LENGTH = 7;
  localparam int DEF_ACK_TIMEOUT        = 15;
  localparam int NUM_CHANNELS           = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_ROW  = 3'd1,
    ST_WAIT_ROW = 3'd2,
    ST_REQ_COL  = 3'd3,
    ST_WAIT_COL = 3'd4,
    ST_READY    = 3'd5
  } fetch_state_t;

  // Each channel takes its bit from the column word when selected, else the row word.
  function automatic logic [NUM_CHANNELS-1:0] merge_words(
    input logic [NUM_CHANNELS-1:0] sel,
    input logic [NUM_CHANNELS-1:0] row_word,
    input logic [NUM_CHANNELS-1:0] col_word
  );
    return (sel & col_word) | (~sel & row_word);
  endfunction

endpackage

// File: rtl/pattern_fetch_driver_mem_reader.sv
// pattern_mem_reader: one memory read handshake. A start pulse registers the
// request; the request is held until mem_ack or until the down-counter hits
// its terminal count, whichever comes first.
module pattern_mem_reader
  import pattern_fetch_driver_pkg::*;
#(
  parameter int ADDR_W      = DEF_MEM_ADDRESS_LENGTH + 1,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_cycle_d;

  // Ack is only honoured while a request is outstanding; anything else is ignored.
  assign done_o       = req_q & mem_ack_i;
  assign last_cycle_d = (cnt_q == CNT_W'(1));
  assign timeout_o    = req_q & ~mem_ack_i & last_cycle_d;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;

  // Request/address registers and the ack wait down-counter.
  always_ff @(posedge clock) begin
    if (clear_i) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      req_q  <= 1'b1;
      addr_q <= addr_i;
      cnt_q  <= CNT_W'(ACK_TIMEOUT);
    end else if (req_q) begin
      if (mem_ack_i || last_cycle_d) begin
        req_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_fetch_driver.sv
// pattern_fetch_driver: fetches a row word and a column word for the current
// pattern coordinate, merges them per channel and drives the motor lines
// during the output window.
//
//   state    | meaning
//   IDLE     | waiting for a new coordinate
//   REQ_ROW  | issue row read {0,row}
//   WAIT_ROW | row read outstanding
//   REQ_COL  | issue column read {1,col}
//   WAIT_COL | column read outstanding
//   READY    | merged word waits for a closed window, then loads
module pattern_fetch_driver
  import pattern_fetch_driver_pkg::*;
#(
  parameter int MEM_ADDRESS_LENGTH = DEF_MEM_ADDRESS_LENGTH,
  parameter int ACK_TIMEOUT        = DEF_ACK_TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  input  logic                          output_active,
  input  logic                          update_cycle_complete,
  input  logic [NUM_CHANNELS-1:0]       inverter_select,
  input  logic [NUM_CHANNELS-1:0]       row_col_select,
  output logic                          mem_req,
  output logic [MEM_ADDRESS_LENGTH:0]   mem_addr,
  input  logic                          mem_ack,
  input  logic [NUM_CHANNELS-1:0]       mem_rdata,
  output logic [NUM_CHANNELS-1:0]       driver_out,
  output logic                          underrun,
  output logic                          fetch_error
);

  localparam int AW = MEM_ADDRESS_LENGTH;

  fetch_state_t            state_q;
  logic [AW-1:0]           fetch_row_q, fetch_col_q;
  logic [AW-1:0]           last_row_q, last_col_q;
  logic                    coord_valid_q;
  logic [NUM_CHANNELS-1:0] row_word_q, col_word_q, active_q, driver_q;
  logic                    oa_prev_q, underrun_q, fetch_error_q;

  logic                    clear_d, need_fetch_d, rd_start_d, rd_done, rd_timeout;
  logic [AW:0]             rd_addr_d;
  logic [NUM_CHANNELS-1:0] shadow_d;

  // Disable is treated exactly like reset.
  assign clear_d      = reset | ~enable;
  assign need_fetch_d = ~update_cycle_complete &
                        (~coord_valid_q | (row_select != last_row_q) | (col_select != last_col_q));
  assign rd_start_d   = (state_q == ST_REQ_ROW) | (state_q == ST_REQ_COL);
  assign rd_addr_d    = (state_q == ST_REQ_COL) ? {1'b1, fetch_col_q} : {1'b0, fetch_row_q};
  assign shadow_d     = merge_words(row_col_select, row_word_q, col_word_q);

  pattern_mem_reader #(
    .ADDR_W      (AW + 1),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_reader (
    .clock      (clock),
    .clear_i    (clear_d),
    .start_i    (rd_start_d),
    .addr_i     (rd_addr_d),
    .mem_ack_i  (mem_ack),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .done_o     (rd_done),
    .timeout_o  (rd_timeout)
  );

  // Fetch sequencer: two reads per coordinate, then load into the active word.
  always_ff @(posedge clock) begin
    if (clear_d) begin
      state_q       <= ST_IDLE;
      fetch_row_q   <= '0;
      fetch_col_q   <= '0;
      last_row_q    <= '0;
      last_col_q    <= '0;
      coord_valid_q <= 1'b0;
      row_word_q    <= '0;
      col_word_q    <= '0;
      active_q      <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (need_fetch_d) begin
            fetch_row_q <= row_select;
            fetch_col_q <= col_select;
            state_q     <= ST_REQ_ROW;
          end
        end
        ST_REQ_ROW: state_q <= ST_WAIT_ROW;
        ST_WAIT_ROW: begin
          if (rd_done) begin
            row_word_q <= mem_rdata;
            state_q    <= ST_REQ_COL;
          end else if (rd_timeout) begin
            fetch_error_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        ST_REQ_COL: state_q <= ST_WAIT_COL;
        ST_WAIT_COL: begin
          if (rd_done) begin
            col_word_q    <= mem_rdata;
            last_row_q    <= fetch_row_q;
            last_col_q    <= fetch_col_q;
            coord_valid_q <= 1'b1;
            state_q       <= ST_READY;
          end else if (rd_timeout) begin
            fetch_error_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        ST_READY: begin
          if (!output_active) begin
            active_q <= shadow_d;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky underrun: window opened while a fetch was still in flight.
  always_ff @(posedge clock) begin
    if (clear_d) begin
      oa_prev_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      oa_prev_q <= output_active;
      if (output_active && !oa_prev_q && (state_q != ST_IDLE)) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // Registered driver lines; polarity inversion applies even outside the window.
  always_ff @(posedge clock) begin
    if (clear_d) begin
      driver_q <= inverter_select;
    end else begin
      driver_q <= ({NUM_CHANNELS{output_active & ~update_cycle_complete}} & active_q)
                  ^ inverter_select;
    end
  end

  assign driver_out  = driver_q;
  assign underrun    = underrun_q;
  assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_pattern_fetch_driver.sv
// Directed bench for pattern_fetch_driver with a latency-programmable memory responder.
module tb_pattern_fetch_driver;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [6:0]  row_select, col_select;
  logic        output_active, update_cycle_complete;
  logic [15:0] inverter_select, row_col_select;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] driver_out;
  logic        underrun, fetch_error;

  int          total = 0;
  int          bad = 0;
  int          ack_lat = 2;
  bit          ack_hold = 1'b0;
  bit          force_ack = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] row_mem [128];
  logic [15:0] col_mem [128];

  pattern_fetch_driver dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .row_select            (row_select),
    .col_select            (col_select),
    .output_active         (output_active),
    .update_cycle_complete (update_cycle_complete),
    .inverter_select       (inverter_select),
    .row_col_select        (row_col_select),
    .mem_req               (mem_req),
    .mem_addr              (mem_addr),
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata),
    .driver_out            (driver_out),
    .underrun              (underrun),
    .fetch_error           (fetch_error)
  );

  always #5 clock = ~clock;

  // Memory model: acks the ack_lat-th cycle of an outstanding request.
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hFFFF;
    end else if (mem_req === 1'b1 && !ack_hold) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr[7] ? col_mem[mem_addr[6:0]] : row_mem[mem_addr[6:0]];
        wait_cnt  = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input logic level, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (mem_req === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_req); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", mem_addr); end
    total++; if (driver_out !== 16'h5A5A) begin bad++; $display("FAIL reset_drv got=%h want=5a5a", driver_out); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (fetch_error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", fetch_error); end
  endtask

  task automatic test_basic();
    bit ok;
    inverter_select = 16'h0000;
    reset = 1'b0;
    wait_req(1'b1, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_row_req timeout got=0 want=1"); end
    total++; if (mem_addr !== 8'h03) begin bad++; $display("FAIL basic_row_addr got=%h want=03", mem_addr); end
    wait_req(1'b0, 10, ok);
    wait_req(1'b1, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_col_req timeout got=0 want=1"); end
    total++; if (mem_addr !== 8'h85) begin bad++; $display("FAIL basic_col_addr got=%h want=85", mem_addr); end
    wait_req(1'b0, 10, ok);
    repeat (3) tick();
    output_active = 1'b1;
    tick();
    total++; if (driver_out !== 16'hF0FF) begin bad++; $display("FAIL basic_drive got=%h want=f0ff", driver_out); end
  endtask

  task automatic test_invert();
    output_active = 1'b0;
    inverter_select = 16'h0001;
    repeat (2) tick();
    total++; if (driver_out !== 16'h0001) begin bad++; $display("FAIL inv_idle got=%h want=0001", driver_out); end
    output_active = 1'b1;
    tick();
    total++; if (driver_out !== 16'hF0FE) begin bad++; $display("FAIL inv_active got=%h want=f0fe", driver_out); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    inverter_select = 16'h0000;
    tick();
    ack_hold = 1'b1;
    row_select = 7'd7;
    col_select = 7'd9;
    wait_req(1'b1, 5, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_req timeout got=0 want=1"); end
    total++; if (fetch_error !== 1'b0) begin bad++; $display("FAIL to_ferr_early got=%b want=0", fetch_error); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req === 1'b1) n++;
      else break;
    end
    total++; if (n != 15) begin bad++; $display("FAIL to_wait_cycles got=%0d want=15", n); end
    total++; if (fetch_error !== 1'b1) begin bad++; $display("FAIL to_ferr got=%b want=1", fetch_error); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b want=0", mem_req); end
    total++; if (driver_out !== 16'hF0FF) begin bad++; $display("FAIL to_drv_keep got=%h want=f0ff", driver_out); end
    wait_req(1'b1, 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_retry timeout got=0 want=1"); end
    total++; if (mem_addr !== 8'h07) begin bad++; $display("FAIL to_retry_addr got=%h want=07", mem_addr); end
    ack_hold = 1'b0;
  endtask

  task automatic test_underrun();
    repeat (15) tick();
    total++; if (driver_out !== 16'hF0FF) begin bad++; $display("FAIL ur_hold_old got=%h want=f0ff", driver_out); end
    output_active = 1'b0;
    repeat (2) tick();
    output_active = 1'b1;
    tick();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clean got=%b want=0", underrun); end
    total++; if (driver_out !== 16'hAB34) begin bad++; $display("FAIL ur_new_word got=%h want=ab34", driver_out); end
    output_active = 1'b0;
    repeat (2) tick();
    ack_lat = 4;
    row_select = 7'd3;
    col_select = 7'd5;
    tick();
    output_active = 1'b1;
    tick();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set got=%b want=1", underrun); end
    total++; if (driver_out !== 16'hAB34) begin bad++; $display("FAIL ur_old_start got=%h want=ab34", driver_out); end
    repeat (18) tick();
    total++; if (driver_out !== 16'hAB34) begin bad++; $display("FAIL ur_old_end got=%h want=ab34", driver_out); end
    output_active = 1'b0;
    repeat (2) tick();
    output_active = 1'b1;
    tick();
    total++; if (driver_out !== 16'hF0FF) begin bad++; $display("FAIL ur_loaded got=%h want=f0ff", driver_out); end
  endtask

  task automatic test_freeze();
    int reqs;
    bit ok;
    update_cycle_complete = 1'b1;
    inverter_select = 16'h00F0;
    row_select = 7'd7;
    col_select = 7'd9;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req !== 1'b0) reqs++;
    end
    total++; if (reqs != 0) begin bad++; $display("FAIL frz_no_req got=%0d want=0", reqs); end
    total++; if (driver_out !== 16'h00F0) begin bad++; $display("FAIL frz_drv got=%h want=00f0", driver_out); end
    update_cycle_complete = 1'b0;
    wait_req(1'b1, 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL frz_resume timeout got=0 want=1"); end
    repeat (15) tick();
  endtask

  task automatic test_enable();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL en_sticky_ur got=%b want=1", underrun); end
    total++; if (fetch_error !== 1'b1) begin bad++; $display("FAIL en_sticky_fe got=%b want=1", fetch_error); end
    enable = 1'b0;
    tick();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL en_ur_clr got=%b want=0", underrun); end
    total++; if (fetch_error !== 1'b0) begin bad++; $display("FAIL en_fe_clr got=%b want=0", fetch_error); end
    total++; if (driver_out !== 16'h00F0) begin bad++; $display("FAIL en_drv got=%h want=00f0", driver_out); end
    enable = 1'b1;
  endtask

  task automatic test_reset_midread();
    bit ok;
    ack_lat = 2;
    wait_req(1'b1, 10, ok);
    wait_req(1'b0, 10, ok);
    ack_hold = 1'b1;
    wait_req(1'b1, 10, ok);
    total++; if (!ok || mem_addr !== 8'h89) begin bad++; $display("FAIL rm_col_addr got=%h want=89", mem_addr); end
    reset = 1'b1;
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b want=0", mem_req); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL rm_addr got=%h want=00", mem_addr); end
    total++; if (driver_out !== 16'h00F0) begin bad++; $display("FAIL rm_drv got=%h want=00f0", driver_out); end
    ack_hold = 1'b0;
    reset = 1'b0;
    tick();
    total++; if (driver_out !== 16'h00F0) begin bad++; $display("FAIL rm_no_capture got=%h want=00f0", driver_out); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      row_mem[i] = 16'h1000 | 16'(i);
      col_mem[i] = 16'h2000 | 16'(i);
    end
    row_mem[3] = 16'h00FF;
    col_mem[5] = 16'hF0F0;
    row_mem[7] = 16'h1234;
    col_mem[9] = 16'hABCD;
    reset = 1'b1;
    enable = 1'b1;
    row_select = 7'd3;
    col_select = 7'd5;
    output_active = 1'b0;
    update_cycle_complete = 1'b0;
    inverter_select = 16'h5A5A;
    row_col_select = 16'hFF00;
    repeat (3) tick();
    test_reset();
    test_basic();
    test_invert();
    test_timeout();
    test_underrun();
    test_freeze();
    test_enable();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
